// File: rtl/pipe_pkg.sv
// Shared types and constants for the fetch/decode instruction buffer.
package pipe_pkg;
  localparam int PIPE_INSTR_W = 32;
  localparam int PIPE_PC_W    = 32;

  localparam logic [PIPE_INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [PIPE_INSTR_W-1:0] instr;
    logic [PIPE_PC_W-1:0]    pc;
    logic [PIPE_PC_W-1:0]    pc_plus4;
  } pipe_entry_t;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/pipe_ptr_ctrl.sv
// Head/tail/occupancy tracking for instr_pipe_buffer; flush overrides push and pop.
module pipe_ptr_ctrl
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CW    = cnt_w(DEPTH)
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_ready,
  output logic             out_valid,
  output logic             wr_en,
  output logic [PTR_W-1:0] head,
  output logic [PTR_W-1:0] tail,
  output logic [CW-1:0]    count
);
  logic push, pop;

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !FLUSH;
  assign pop       = out_valid && out_ready && !FLUSH;
  assign wr_en     = push;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)     count <= '0;
    else if (FLUSH) count <= '0;
    else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  generate
    if (DEPTH == 1) begin : g_single
      assign head = '0;
      assign tail = '0;
    end else begin : g_multi
      // Power-of-two depth: natural pointer overflow is the wrap.
      always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
          head <= '0;
          tail <= '0;
        end else if (FLUSH) begin
          head <= '0;
          tail <= '0;
        end else begin
          if (push) tail <= tail + PTR_W'(1);
          if (pop)  head <= head + PTR_W'(1);
        end
      end
    end
  endgenerate
endmodule

// File: rtl/instr_pipe_buffer.sv
// Handshaked IF/ID instruction buffer: entry storage, NOP output mux, back-pressure counter.
module instr_pipe_buffer
  import pipe_pkg::*;
#(
  parameter int DEPTH   = 2,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32,
  parameter int CNT_W   = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       FLUSH,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [PC_W-1:0]            in_pc,
  input  logic [PC_W-1:0]            in_pc_plus4,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [PC_W-1:0]            out_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           stall_cnt
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_plus4;
  } entry_t;

  logic             wr_en;
  logic [PTR_W-1:0] head, tail;
  entry_t           mem [DEPTH];
  entry_t           head_e;

  pipe_ptr_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .CW(CW)) u_ptr (
    .CLK      (CLK),
    .RESET    (RESET),
    .FLUSH    (FLUSH),
    .in_valid (in_valid),
    .out_ready(out_ready),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .wr_en    (wr_en),
    .head     (head),
    .tail     (tail),
    .count    (count)
  );

  // Storage is never cleared; the output mux alone hides stale entries.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[tail] <= '{instr: in_instr, pc: in_pc, pc_plus4: in_pc_plus4};
  end

  assign head_e       = mem[head];
  assign out_instr    = out_valid ? head_e.instr    : INSTR_W'(NOP_INSTR);
  assign out_pc       = out_valid ? head_e.pc       : '0;
  assign out_pc_plus4 = out_valid ? head_e.pc_plus4 : '0;

  // Counts through flush cycles too; only RESET clears it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end
endmodule

// File: tb/tb_instr_pipe_buffer.sv
// Directed bench for instr_pipe_buffer: DEPTH=2/CNT_W=16 main instance, DEPTH=4/CNT_W=4 saturation instance.
module tb_instr_pipe_buffer;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  always #5 CLK = ~CLK;

  // main instance
  logic        FLUSH, in_valid, out_ready, in_ready, out_valid;
  logic [31:0] in_instr, in_pc, in_pc_plus4, out_instr, out_pc, out_pc_plus4;
  logic [1:0]  count;
  logic [15:0] stall_cnt;

  // saturation instance
  logic        s_flush, s_in_valid, s_out_ready, s_in_ready, s_out_valid;
  logic [31:0] s_in_instr, s_out_instr, s_out_pc, s_out_pc_plus4;
  logic [2:0]  s_count;
  logic [3:0]  s_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  instr_pipe_buffer #(.DEPTH(2), .INSTR_W(32), .PC_W(32), .CNT_W(16)) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_pc_plus4(in_pc_plus4),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .count(count), .stall_cnt(stall_cnt)
  );

  instr_pipe_buffer #(.DEPTH(4), .INSTR_W(32), .PC_W(32), .CNT_W(4)) dut_sat (
    .CLK(CLK), .RESET(RESET), .FLUSH(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_instr(s_in_instr), .in_pc(32'h0000_0400), .in_pc_plus4(32'h0000_0404),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_instr(s_out_instr), .out_pc(s_out_pc), .out_pc_plus4(s_out_pc_plus4),
    .count(s_count), .stall_cnt(s_stall_cnt)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    in_valid    = v;
    in_instr    = instr;
    in_pc       = pc;
    in_pc_plus4 = pc + 32'd4;
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    #3;
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_instr !== 32'h0 || out_pc !== 32'h0 || out_pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_data got %h/%h/%h want 0/0/0", out_instr, out_pc, out_pc_plus4); end
    n_checks++; if (count !== 2'd0)     begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
    @(posedge CLK); #1;
    RESET = 1'b1;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 32'h8C01_0004, 32'h100);
    step();
    drive(1'b0, 32'h0, 32'h0);
    n_checks++; if (out_valid !== 1'b1 || out_instr !== 32'h8C01_0004) begin
      n_fail++; $display("FAIL single_head got v=%b %h want v=1 8c010004", out_valid, out_instr); end
    n_checks++; if (out_pc !== 32'h100 || out_pc_plus4 !== 32'h104) begin
      n_fail++; $display("FAIL single_pc got %h/%h want 100/104", out_pc, out_pc_plus4); end
    step();
    n_checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0) begin
      n_fail++; $display("FAIL single_drain got v=%b %h pc=%h want v=0 0 0", out_valid, out_instr, out_pc); end
  endtask

  task automatic test_full();
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 32'h200); step();
    drive(1'b1, 32'hBBBB_0002, 32'h204); step();
    n_checks++; if (in_ready !== 1'b0 || count !== 2'd2) begin
      n_fail++; $display("FAIL full_state got rdy=%b cnt=%0d want rdy=0 cnt=2", in_ready, count); end
    drive(1'b1, 32'hCCCC_0003, 32'h208); step();
    drive(1'b0, 32'h0, 32'h0);
    n_checks++; if (count !== 2'd2 || out_instr !== 32'hAAAA_0001) begin
      n_fail++; $display("FAIL full_ignore got cnt=%0d head=%h want 2 aaaa0001", count, out_instr); end
    step();
    out_ready = 1'b1;
    step();
    n_checks++; if (out_instr !== 32'hBBBB_0002 || out_pc_plus4 !== 32'h208 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL full_second got %h p4=%h rdy=%b want bbbb0002 208 1", out_instr, out_pc_plus4, in_ready); end
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL full_drain got v=%b want 0", out_valid); end
    n_checks++; if (stall_cnt !== 16'd3) begin n_fail++; $display("FAIL full_stall got %0d want 3", stall_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    int errs;
    errs = 0;
    out_ready = 1'b1;
    drive(1'b1, 32'h5000_0000, 32'h300); step();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 32'h5000_0000 + i, 32'h300 + 4 * i);
      step();
      exp = 32'h5000_0000 + i;
      if (count !== 2'd1 || out_instr !== exp || out_pc !== 32'h300 + 4 * i) begin
        errs++;
        $display("FAIL stream_%0d got cnt=%0d %h pc=%h want 1 %h %h", i, count, out_instr, out_pc, exp, 32'h300 + 4 * i);
      end
    end
    n_checks++; if (errs != 0) n_fail++;
    drive(1'b0, 32'h0, 32'h0); step();
    n_checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd3) begin
      n_fail++; $display("FAIL stream_end got v=%b stall=%0d want 0 3", out_valid, stall_cnt); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'hDDDD_0004, 32'h500); step();
    drive(1'b1, 32'hEEEE_0005, 32'h504); step();
    FLUSH = 1'b1;
    drive(1'b1, 32'hFFFF_0006, 32'h508); step();
    n_checks++; if (count !== 2'd0 || out_valid !== 1'b0 || out_instr !== 32'h0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_full got cnt=%0d v=%b %h rdy=%b want 0 0 0 1", count, out_valid, out_instr, in_ready); end
    FLUSH = 1'b0;
    drive(1'b0, 32'h0, 32'h0); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop got v=%b %h want 0", out_valid, out_instr); end
    drive(1'b1, 32'h1111_0007, 32'h600); step();
    FLUSH = 1'b1;
    drive(1'b1, 32'h2222_0008, 32'h604); step();
    FLUSH = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    n_checks++; if (count !== 2'd0 || out_instr !== 32'h0) begin
      n_fail++; $display("FAIL flush_one got cnt=%0d %h want 0 0", count, out_instr); end
    step();
    n_checks++; if (out_valid !== 1'b0 || stall_cnt !== 16'd6) begin
      n_fail++; $display("FAIL flush_after got v=%b stall=%0d want 0 6", out_valid, stall_cnt); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h3333_0009, 32'h700); step();
    drive(1'b0, 32'h0, 32'h0);
    n_checks++; if (count !== 2'd1) begin n_fail++; $display("FAIL areset_pre got cnt=%0d want 1", count); end
    #2 RESET = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || out_pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL areset_out got v=%b %h %h %h want 0", out_valid, out_instr, out_pc, out_pc_plus4); end
    n_checks++; if (count !== 2'd0 || stall_cnt !== 16'd0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL areset_state got cnt=%0d stall=%0d rdy=%b want 0 0 1", count, stall_cnt, in_ready); end
    @(posedge CLK); #1;
    RESET = 1'b1;
  endtask

  task automatic test_saturate();
    s_out_ready = 1'b0;
    s_in_instr  = 32'h7777_0000;
    s_in_valid  = 1'b1; step();
    s_in_valid  = 1'b0;
    for (int i = 0; i < 20; i++) step();
    n_checks++; if (s_stall_cnt !== 4'd15 || s_count !== 3'd1) begin
      n_fail++; $display("FAIL sat_hold got stall=%0d cnt=%0d want 15 1", s_stall_cnt, s_count); end
    s_flush = 1'b1; step();
    s_flush = 1'b0;
    n_checks++; if (s_stall_cnt !== 4'd15 || s_count !== 3'd0 || s_out_instr !== 32'h0) begin
      n_fail++; $display("FAIL sat_flush got stall=%0d cnt=%0d %h want 15 0 0", s_stall_cnt, s_count, s_out_instr); end
    #2 RESET = 1'b0;
    #1;
    n_checks++; if (s_stall_cnt !== 4'd0) begin n_fail++; $display("FAIL sat_reset got %0d want 0", s_stall_cnt); end
    @(posedge CLK); #1;
    RESET = 1'b1;
  endtask

  initial begin
    FLUSH = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_instr = 32'h0;
    test_reset();
    test_single();
    test_full();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
